// File: rtl/adder_seq_32bit.sv
// ============================================================================
// Module   : adder_seq_32bit
// Brief    : Byte-serial wide adder sequencer driving an external 8-bit adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_seq_32bit #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_carry,
    output logic [7:0]          add_A,
    output logic [7:0]          add_B,
    output logic                add_C,
    input  logic [7:0]          add_sum,
    input  logic                add_carry
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic            r_c;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_out_sum;
    logic            r_out_carry;
    logic [W-1:0]    w_res_next;
    logic            w_last;

    assign w_last = (r_idx == c_LAST_IDX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Result with the current adder byte merged in at the active lane.
    always_comb begin
        w_res_next = r_res;
        w_res_next[8*r_idx +: 8] = add_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_c         <= 1'b0;
            r_idx       <= '0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_c   <= in_cin;
                        r_idx <= '0;
                    end
                end
                S_RUN: begin
                    r_res <= w_res_next;
                    r_c   <= add_carry;
                    if (w_last) begin
                        // Published copy stays put while the next operation
                        // reloads the carry chain and rebuilds the result.
                        r_out_sum   <= w_res_next;
                        r_out_carry <= add_carry;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;

    assign add_A = (r_state == S_RUN) ? r_a[8*r_idx +: 8] : 8'h00;
    assign add_B = (r_state == S_RUN) ? r_b[8*r_idx +: 8] : 8'h00;
    assign add_C = (r_state == S_RUN) ? r_c : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_adder_seq_32bit.sv
// ============================================================================
// Module   : tb_adder_seq_32bit
// Brief    : Self-checking bench for adder_seq_32bit with an 8-bit adder model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder_seq_32bit;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic [7:0]   add_A;
    logic [7:0]   add_B;
    logic         add_C;
    logic [7:0]   add_sum;
    logic         add_carry;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    adder_seq_32bit #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .add_A     (add_A),
        .add_B     (add_B),
        .add_C     (add_C),
        .add_sum   (add_sum),
        .add_carry (add_carry)
    );

    // The external combinational 8-bit adder
    assign {add_carry, add_sum} = {1'b0, add_A} + {1'b0, add_B} + {8'h00, add_C};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic check_run(input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input int hold);
        logic [63:0] exp_full;
        logic [63:0] mask;
        logic [63:0] cinto;
        exp_full  = {32'h0, a} + {32'h0, b} + {63'h0, cin};
        out_ready = (hold == 0);
        for (int s = 0; s < NB; s++) begin
            mask  = (64'h1 << (8 * s)) - 64'h1;
            cinto = (({32'h0, a} & mask) + ({32'h0, b} & mask) + {63'h0, cin}) >> (8 * s);
            chk("add_A_step", {56'h0, add_A}, ({32'h0, a} >> (8 * s)) & 64'hFF);
            chk("add_B_step", {56'h0, add_B}, ({32'h0, b} >> (8 * s)) & 64'hFF);
            chk("add_C_step", {63'h0, add_C}, cinto & 64'h1);
            chk("out_valid_run", {63'h0, out_valid}, 64'h0);
            chk("in_ready_run", {63'h0, in_ready}, 64'h0);
            @(negedge clk);
        end
        chk("out_valid_done", {63'h0, out_valid}, 64'h1);
        chk("out_sum", {32'h0, out_sum}, exp_full & 64'hFFFF_FFFF);
        chk("out_carry", {63'h0, out_carry}, (exp_full >> 32) & 64'h1);
        chk("in_ready_done", {63'h0, in_ready}, 64'h0);
        chk("add_A_done", {56'h0, add_A}, 64'h0);
        chk("add_C_done", {63'h0, add_C}, 64'h0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            @(negedge clk);
            chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
            chk("bp_out_sum", {32'h0, out_sum}, exp_full & 64'hFFFF_FFFF);
            chk("bp_out_carry", {63'h0, out_carry}, (exp_full >> 32) & 64'h1);
            chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
        end
        if (hold > 0) in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_out_valid", {63'h0, out_valid}, 64'h0);
        chk("idle_in_ready", {63'h0, in_ready}, 64'h1);
        chk("idle_sum_held", {32'h0, out_sum}, exp_full & 64'hFFFF_FFFF);
        chk("idle_carry_held", {63'h0, out_carry}, (exp_full >> 32) & 64'h1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin);
        chk("issue_in_ready", {63'h0, in_ready}, 64'h1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_cin   = ~cin;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        int          k1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_out_sum", {32'h0, out_sum}, 64'h0);
        chk("rst_out_carry", {63'h0, out_carry}, 64'h0);
        chk("rst_add_A", {56'h0, add_A}, 64'h0);
        chk("rst_add_B", {56'h0, add_B}, 64'h0);
        chk("rst_add_C", {63'h0, add_C}, 64'h0);

        // Directed cases
        issue(32'h0000_0010, 32'h0000_0012, 1'b0);
        check_run(32'h0000_0010, 32'h0000_0012, 1'b0, 0);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check_run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        issue(32'hAAAA_AABF, 32'h5555_55AD, 1'b0);
        check_run(32'hAAAA_AABF, 32'h5555_55AD, 1'b0, 0);

        // Back-to-back with in_valid held high
        in_valid = 1'b1;
        in_a     = 32'h7FFF_FFFF;
        in_b     = 32'h0000_0000;
        in_cin   = 1'b1;
        @(negedge clk);
        k1     = cyc;
        in_a   = 32'h1234_5678;
        in_b   = 32'h9ABC_DEF0;
        in_cin = 1'b0;
        check_run(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_gap", 64'(cyc - k1), 64'(NB + 2));
        check_run(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0);

        // Backpressure
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        check_run(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 5);

        // Random operands with random backpressure
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc);
            check_run(ra, rb, rc, int'($urandom_range(0, 2)));
        end

        // Reset on the second RUN edge
        issue(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("mid_rst_out_sum", {32'h0, out_sum}, 64'h0);
        chk("mid_rst_out_carry", {63'h0, out_carry}, 64'h0);
        chk("mid_rst_add_A", {56'h0, add_A}, 64'h0);
        chk("mid_rst_add_B", {56'h0, add_B}, 64'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale_valid", {63'h0, out_valid}, 64'h0);
        end

        // Recovery after reset
        issue(32'h0000_00FF, 32'h0000_0001, 1'b1);
        check_run(32'h0000_00FF, 32'h0000_0001, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
